// File: rtl/tt_check_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
package tt_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tt_state_e;

  // Largest truth table the lookup helper accepts (N_IN up to 10).
  localparam int TBL_MAX_LOG2 = 10;
  localparam int TBL_MAX      = 1 << TBL_MAX_LOG2;

  // Expected DUT output for input vector idx; bit idx of the table.
  function automatic logic truth_bit(input logic [TBL_MAX-1:0]      tbl,
                                     input logic [TBL_MAX_LOG2-1:0] idx);
    return tbl[idx];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins over increment; increment stops at all-ones.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps every input vector of an N_IN-input DUT, samples its output SETTLE
// cycles after each vector is presented and compares it to a truth table.
module tt_sweep_checker
  import tt_check_pkg::*;
#(
  parameter int                    N_IN     = 3,
  parameter int                    SETTLE   = 1,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED = 8'b1110_0010,
  parameter int                    ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [N_IN-1:0]  stim,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [N_IN-1:0]  first_err_idx
);

  // Elaboration-time parameter sanity.
  if (SETTLE < 1) begin : g_bad_settle
    $error("tt_sweep_checker: SETTLE must be >= 1");
  end
  if (N_IN < 1) begin : g_bad_n_in
    $error("tt_sweep_checker: N_IN must be >= 1");
  end
  if (N_IN > TBL_MAX_LOG2) begin : g_bad_n_in_max
    $error("tt_sweep_checker: N_IN exceeds truth_bit table size");
  end

  localparam int                SC_W        = $clog2(SETTLE + 1);
  localparam logic [N_IN-1:0]   STIM_LAST   = '1;
  localparam logic [SC_W-1:0]   SETTLE_LAST = SC_W'(SETTLE - 1);
  localparam logic [TBL_MAX-1:0] TBL        = TBL_MAX'(EXPECTED);

  tt_state_e         state_q,  state_d;
  logic [N_IN-1:0]   stim_q,   stim_d;
  logic [SC_W-1:0]   settle_q, settle_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic              pass_q,   pass_d;
  logic              fev_q,    fev_d;
  logic [N_IN-1:0]   fei_q,    fei_d;

  logic              err_clr;
  logic              err_inc;
  logic              exp_bit;
  logic              sample;
  logic              mismatch;
  logic [ERR_W-1:0]  err_cnt;

  assign exp_bit  = truth_bit(TBL, TBL_MAX_LOG2'(stim_q));
  assign sample   = (state_q == RUN) && (settle_q == SETTLE_LAST);
  assign mismatch = sample && (dut_y != exp_bit);

  // Next-state and next-output logic for the IDLE/RUN/DONE sweep sequencer.
  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    settle_d = settle_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    fev_d    = fev_q;
    fei_d    = fei_q;
    err_clr  = 1'b0;
    err_inc  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        // A new sweep discards every result of the previous one.
        if (start) begin
          state_d  = RUN;
          stim_d   = '0;
          settle_d = '0;
          err_clr  = 1'b1;
          fev_d    = 1'b0;
          fei_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
        end
      end
      RUN: begin
        if (!sample) begin
          settle_d = settle_q + SC_W'(1);
        end else begin
          err_inc = mismatch;
          if (mismatch && !fev_q) begin
            fev_d = 1'b1;
            fei_d = stim_q;
          end
          // Terminal vector is detected before incrementing, so stim never wraps.
          if (stim_q == STIM_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // The last sample's mismatch is not yet in err_cnt, so include it here.
            pass_d  = (err_cnt == '0) && !mismatch;
          end else begin
            stim_d   = stim_q + N_IN'(1);
            settle_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer and result registers; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      stim_q   <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fev_q    <= 1'b0;
      fei_q    <= '0;
    end else begin
      state_q  <= state_d;
      stim_q   <= stim_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fev_q    <= fev_d;
      fei_q    <= fei_d;
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (err_clr),
    .inc   (err_inc),
    .count (err_cnt)
  );

  assign stim            = stim_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_cnt;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: three checker instances (default, ERR_W=2,
// SETTLE=3) each watching a behavioural DUT model of AB+!BC.
module tb_tt_sweep_checker;

  typedef enum int {M_OK, M_FLIP3, M_STUCK0, M_STUCK1, M_INV, M_REG} mode_e;

  typedef struct {
    int          inst;
    mode_e       mode;
    bit          hold;
    int          exp_cyc;
    logic [7:0]  exp_err;
    logic        exp_pass;
    logic        exp_fev;
    logic [2:0]  exp_fei;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_a [3];
  mode_e      mode = M_OK;

  logic [2:0] stim_a [3];
  logic       busy_a [3];
  logic       done_a [3];
  logic       pass_a [3];
  logic [7:0] err_a  [3];
  logic       fev_a  [3];
  logic [2:0] fei_a  [3];
  logic       y_a    [3];

  logic [2:0] stim0, stim1, stim2, fei0, fei1, fei2;
  logic [7:0] err0, err2;
  logic [1:0] err1;
  logic       busy0, busy1, busy2, done0, done1, done2;
  logic       pass0, pass1, pass2, fev0, fev1, fev2;
  logic       r1_0, r2_0, r1_2, r2_2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Independent golden model: y = a&b | ~b&c with {a,b,c} = s.
  function automatic logic golden(input logic [2:0] s);
    return (s[2] & s[1]) | (~s[1] & s[0]);
  endfunction

  // Two-stage registered versions of the golden DUT.
  always @(posedge clk) begin
    r1_0 <= golden(stim0);
    r2_0 <= r1_0;
    r1_2 <= golden(stim2);
    r2_2 <= r1_2;
  end

  always_comb begin
    y_a[0] = golden(stim0);
    case (mode)
      M_OK:     y_a[0] = golden(stim0);
      M_FLIP3:  y_a[0] = golden(stim0) ^ (stim0 == 3'd3);
      M_STUCK0: y_a[0] = 1'b0;
      M_STUCK1: y_a[0] = 1'b1;
      M_INV:    y_a[0] = ~golden(stim0);
      M_REG:    y_a[0] = r2_0;
      default:  y_a[0] = golden(stim0);
    endcase
    y_a[1] = ~golden(stim1);
    y_a[2] = r2_2;
  end

  tt_sweep_checker u_dut (
    .clk (clk), .reset (reset), .start (start_a[0]), .stim (stim0), .dut_y (y_a[0]),
    .busy (busy0), .done (done0), .pass (pass0), .err_count (err0),
    .first_err_valid (fev0), .first_err_idx (fei0)
  );

  tt_sweep_checker #(.ERR_W (2)) u_sat (
    .clk (clk), .reset (reset), .start (start_a[1]), .stim (stim1), .dut_y (y_a[1]),
    .busy (busy1), .done (done1), .pass (pass1), .err_count (err1),
    .first_err_valid (fev1), .first_err_idx (fei1)
  );

  tt_sweep_checker #(.SETTLE (3)) u_slow (
    .clk (clk), .reset (reset), .start (start_a[2]), .stim (stim2), .dut_y (y_a[2]),
    .busy (busy2), .done (done2), .pass (pass2), .err_count (err2),
    .first_err_valid (fev2), .first_err_idx (fei2)
  );

  assign stim_a[0] = stim0;  assign stim_a[1] = stim1;  assign stim_a[2] = stim2;
  assign busy_a[0] = busy0;  assign busy_a[1] = busy1;  assign busy_a[2] = busy2;
  assign done_a[0] = done0;  assign done_a[1] = done1;  assign done_a[2] = done2;
  assign pass_a[0] = pass0;  assign pass_a[1] = pass1;  assign pass_a[2] = pass2;
  assign err_a[0]  = err0;   assign err_a[1]  = {6'd0, err1}; assign err_a[2] = err2;
  assign fev_a[0]  = fev0;   assign fev_a[1]  = fev1;   assign fev_a[2]  = fev2;
  assign fei_a[0]  = fei0;   assign fei_a[1]  = fei1;   assign fei_a[2]  = fei2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input int inst, input string tag);
    check({tag, " stim"}, 32'(stim_a[inst]), 0);
    check({tag, " busy"}, 32'(busy_a[inst]), 0);
    check({tag, " done"}, 32'(done_a[inst]), 0);
    check({tag, " pass"}, 32'(pass_a[inst]), 0);
    check({tag, " err"},  32'(err_a[inst]),  0);
    check({tag, " fev"},  32'(fev_a[inst]),  0);
    check({tag, " fei"},  32'(fei_a[inst]),  0);
  endtask

  // Pulse (or hold) start, then count edges from the start edge until done.
  task automatic do_sweep(input int inst, input bit hold,
                          output int cyc, output int bcyc, output bit ok);
    @(negedge clk);
    start_a[inst] = 1'b1;
    @(posedge clk); #1;
    if (!hold) start_a[inst] = 1'b0;
    check("start busy", 32'(busy_a[inst]), 1);
    check("start done", 32'(done_a[inst]), 0);
    check("start err cleared", 32'(err_a[inst]), 0);
    check("start fev cleared", 32'(fev_a[inst]), 0);
    cyc  = 0;
    bcyc = 1;
    ok   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done_a[inst]) begin
        ok = 1'b1;
        break;
      end
      if (busy_a[inst]) bcyc++;
    end
    start_a[inst] = 1'b0;
  endtask

  vec_t vecs [9];
  vec_t sb_q [$];

  initial begin
    int   cyc, bcyc;
    bit   ok;
    vec_t e;

    for (int i = 0; i < 3; i++) start_a[i] = 1'b0;

    vecs[0] = '{0, M_OK,     1'b0, 8,  8'd0, 1'b1, 1'b0, 3'd0};
    vecs[1] = '{0, M_FLIP3,  1'b0, 8,  8'd1, 1'b0, 1'b1, 3'd3};
    vecs[2] = '{0, M_STUCK0, 1'b0, 8,  8'd4, 1'b0, 1'b1, 3'd1};
    vecs[3] = '{0, M_STUCK1, 1'b0, 8,  8'd4, 1'b0, 1'b1, 3'd0};
    vecs[4] = '{0, M_INV,    1'b0, 8,  8'd8, 1'b0, 1'b1, 3'd0};
    vecs[5] = '{1, M_OK,     1'b0, 8,  8'd3, 1'b0, 1'b1, 3'd0};
    vecs[6] = '{2, M_OK,     1'b0, 24, 8'd0, 1'b1, 1'b0, 3'd0};
    vecs[7] = '{0, M_OK,     1'b1, 8,  8'd0, 1'b1, 1'b0, 3'd0};
    vecs[8] = '{0, M_FLIP3,  1'b0, 8,  8'd1, 1'b0, 1'b1, 3'd3};

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_idle(i, "reset");
    @(negedge clk);
    reset = 1'b0;

    // Table-driven sweeps with scoreboard.
    for (int v = 0; v < 9; v++) begin
      sb_q.push_back(vecs[v]);
      mode = vecs[v].mode;
      do_sweep(vecs[v].inst, vecs[v].hold, cyc, bcyc, ok);
      check("scoreboard nonempty", 32'(sb_q.size()), 1);
      e = sb_q.pop_front();
      check($sformatf("v%0d done in budget", v), 32'(ok), 1);
      check($sformatf("v%0d run length", v), 32'(cyc), 32'(e.exp_cyc));
      check($sformatf("v%0d busy cycles", v), 32'(bcyc), 32'(e.exp_cyc));
      check($sformatf("v%0d busy at done", v), 32'(busy_a[e.inst]), 0);
      check($sformatf("v%0d err_count", v), 32'(err_a[e.inst]), 32'(e.exp_err));
      check($sformatf("v%0d pass", v), 32'(pass_a[e.inst]), 32'(e.exp_pass));
      check($sformatf("v%0d first_err_valid", v), 32'(fev_a[e.inst]), 32'(e.exp_fev));
      if (e.exp_fev)
        check($sformatf("v%0d first_err_idx", v), 32'(fei_a[e.inst]), 32'(e.exp_fei));
      check($sformatf("v%0d stim held", v), 32'(stim_a[e.inst]), 7);
    end

    // Results hold in DONE while start stays low.
    repeat (4) @(posedge clk);
    #1;
    check("hold done", 32'(done_a[0]), 1);
    check("hold err", 32'(err_a[0]), 1);
    check("hold stim", 32'(stim_a[0]), 7);

    // Registered DUT with too little settle time must fail.
    mode = M_REG;
    do_sweep(0, 1'b0, cyc, bcyc, ok);
    check("reg settle1 done", 32'(ok), 1);
    check("reg settle1 pass", 32'(pass_a[0]), 0);
    check("reg settle1 err nonzero", 32'(err_a[0] != 8'd0), 1);

    // Reset in the middle of a sweep clears everything.
    mode = M_FLIP3;
    @(negedge clk);
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (stim_a[0] == 3'd4) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach stim 4", 32'(ok), 1);
    check("pre-reset err", 32'(err_a[0]), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle(0, "midrun reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle after reset busy", 32'(busy_a[0]), 0);
    mode = M_OK;
    do_sweep(0, 1'b0, cyc, bcyc, ok);
    check("post-reset done", 32'(ok), 1);
    check("post-reset length", 32'(cyc), 8);
    check("post-reset pass", 32'(pass_a[0]), 1);
    check("post-reset err", 32'(err_a[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Synthesizable, parametrised truth-table checker for an N-input, 1-output combinational (or short-latency) DUT.
- On `start`, it sweeps every input vector 0 .. 2^N_IN-1. For each vector it waits a settle time, samples the DUT output and compares it against a truth table supplied as a parameter.
- Reports error count, first failing vector and pass/fail.
- Sits beside student/lab DUTs as on-chip self-test, replacing hand-written per-vector benches.

Parameters:
- N_IN, 3: DUT input count; stim width; 2^N_IN vectors swept.
- SETTLE, 1: cycles between presenting a vector and sampling dut_y; must be ≥1.
- EXPECTED, 8'b1110_0010: 2^N_IN-bit truth table; bit i is the expected dut_y for stim == i. The default is AB+!BC with {a,b,c} = stim[2:0].
- ERR_W, 8: width of the error counter.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: begin a sweep; honoured in IDLE or DONE only.
- stim, out, N_IN: vector driven to the DUT inputs.
- dut_y, in, 1: DUT output under test.
- busy, out, 1: high while a sweep is running.
- done, out, 1: high in DONE until the next start or reset.
- pass, out, 1: in DONE, high iff err_count == 0; 0 otherwise.
- err_count, out, ERR_W: mismatches in the current/last sweep; saturating.
- first_err_valid, out, 1: at least one mismatch recorded this sweep.
- first_err_idx, out, N_IN: lowest stim value that mismatched; valid when first_err_valid.

Behaviour:
- Clock and reset: single clock domain, clk. reset is synchronous and active-high, and is sampled only on the clk rising edge.
- Reset values: state = IDLE; all outputs = 0 (stim, busy, done, pass, err_count, first_err_valid, first_err_idx); settle counter = 0.
- Reset during RUN aborts the sweep immediately. No partial results are retained.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start = 1 → RUN.
  - On the same edge: stim = 0, settle_cnt = 0, err_count = 0, first_err_valid = 0, first_err_idx = 0, busy = 1, done = 0, pass = 0.
- RUN, each edge:
  - If settle_cnt ≠ SETTLE-1: settle_cnt++.
  - Else (sample edge): compare dut_y against EXPECTED[stim].
  - On mismatch: err_count++, saturating at 2^ERR_W-1. If first_err_valid = 0, set first_err_idx = stim and first_err_valid = 1.
  - After a sample, if stim == 2^N_IN-1 → DONE: busy = 0, done = 1, pass = (final err_count == 0). The final count includes the current sample's mismatch.
  - After a sample otherwise: stim++, settle_cnt = 0.
- Sampling latency: dut_y is sampled exactly SETTLE cycles after stim changes.
- Run length: done rises exactly 2^N_IN × SETTLE edges after the start edge.
- Out-of-state start:
  - start in RUN is ignored; there is no restart.
  - start in DONE behaves as in IDLE and starts a new sweep, clearing all results.
- DONE hold: stim holds at 2^N_IN-1 and all results hold until start or reset.
- Arithmetic and width rules:
  - stim does not wrap during a sweep; the terminal value is detected before increment.
  - settle_cnt width is $clog2(SETTLE+1).
- dut_y is treated as 2-state. X-propagation is a bench concern, not an RTL concern.
- Elaboration checks: SETTLE < 1 or N_IN < 1 is an elaboration error ($error in an initial/generate check).

Decomposition:
- Package tt_check_pkg holds:
  - state enum tt_state_e {IDLE, RUN, DONE};
  - function truth_bit(table, idx) for the EXPECTED lookup.
- One sub-module, sat_counter #(W): synchronous clear, increment enable, saturation at all-ones. Used for err_count.
- settle_cnt and stim stay inline in the top module.

Test Plan:
- Correct DUT: correct AB+!BC model on stim, default params; pulse start → done at edge 8, pass = 1, err_count = 0, first_err_valid = 0, busy high for 8 cycles.
- Single fault: DUT that inverts output only for stim = 3 → pass = 0, err_count = 1, first_err_idx = 3, first_err_valid = 1.
- Stuck-at-0 DUT: → err_count = 4, first_err_idx = 1. Saturation with the same DUT: ERR_W = 2, DUT outputting ~expected for all 8 vectors → err_count = 3, pass = 0.
- Registered DUT: DUT with 2-cycle registered latency, SETTLE = 3 → pass = 1, done at edge 24. With SETTLE = 1 the same DUT fails (err_count > 0).
- Reset mid-run: assert reset at stim = 4 → next edge all outputs 0, state IDLE. A subsequent start runs a full clean sweep.
- start handling: start held during RUN → sweep length is unchanged (8 cycles). start in DONE → err_count/first_err cleared and a second sweep completes with fresh results.
